// File: rtl/fetch_stage_if.sv
// fetch_stage_if: groups the fetch-stage control inputs, instruction-memory
// port and IF/ID outputs into one bundle.
// Ports: master = fetch stage (drives imem_addr and ifid_*), slave = core/memory side.
interface fetch_stage_if #(
  parameter int PC_W = 9
) ();
  // control from hazard unit / EX / decode
  logic            stall;
  logic            redirect;
  logic [PC_W-1:0] redirect_pc;
  logic            halt;
  // instruction memory
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  // IF/ID register
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic [6:0]      ifid_opcode;
  logic            ifid_valid;
  logic            halted;
  logic [31:0]     fetch_count;

  modport master (
    input  stall, redirect, redirect_pc, halt, imem_rdata,
    output imem_addr, ifid_pc, ifid_instr, ifid_opcode, ifid_valid, halted, fetch_count
  );

  modport slave (
    output stall, redirect, redirect_pc, halt, imem_rdata,
    input  imem_addr, ifid_pc, ifid_instr, ifid_opcode, ifid_valid, halted, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch plus IF/ID register (PC, stall, redirect, halt).
// Latency: 1 cycle from imem_addr to ifid_*; redirect costs one bubble slot.
// Backpressure: stall holds PC and IF/ID; HALTED is terminal until rst_n.
// Ports: clk, rst_n (async active-low), io (fetch_stage_if.master).
module fetch_stage #(
  parameter int          PC_W     = 9,
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter logic [31:0] NOP      = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master io
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t          state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] ifid_pc;
  logic [31:0]     ifid_instr;
  logic            ifid_valid;
  logic            halted;
  logic [31:0]     fetch_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC[PC_W-1:0];
      ifid_pc     <= '0;
      ifid_instr  <= NOP;
      ifid_valid  <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (io.redirect) begin
            // Branch in EX is older than anything in ID, so a concurrent
            // halt or stall belongs to a squashed instruction.
            pc         <= io.redirect_pc & ~PC_W'(3);
            ifid_pc    <= pc;
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
          end else if (io.halt && ifid_valid) begin
            // A bubble never halts: only a real HALT in ID stops fetch.
            state      <= HALTED;
            halted     <= 1'b1;
            ifid_pc    <= pc;
            ifid_instr <= NOP;
            ifid_valid <= 1'b0;
          end else if (!io.stall) begin
            ifid_pc     <= pc;
            ifid_instr  <= io.imem_rdata;
            ifid_valid  <= 1'b1;
            pc          <= pc + PC_W'(4);
            fetch_count <= fetch_count + 32'd1;
          end
        end
        HALTED: begin
          // terminal: everything holds until reset
        end
        default: state <= RUN;
      endcase
    end
  end

  assign io.imem_addr   = pc;
  assign io.ifid_pc     = ifid_pc;
  assign io.ifid_instr  = ifid_instr;
  assign io.ifid_opcode = ifid_instr[6:0];
  assign io.ifid_valid  = ifid_valid;
  assign io.halted      = halted;
  assign io.fetch_count = fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test of fetch_stage with hand-computed expectations.
// Memory holds word i at byte 4i, except word 127 which is all-ones.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_fetch_stage;
  localparam int PC_W = 9;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  logic [31:0] mem [0:127];

  fetch_stage_if #(.PC_W(PC_W)) io ();

  fetch_stage #(.PC_W(PC_W), .RESET_PC(32'd0), .NOP(32'h00000013)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (io)
  );

  assign io.imem_rdata = mem[io.imem_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic r, input logic [PC_W-1:0] rpc, input logic h);
    io.stall       = s;
    io.redirect    = r;
    io.redirect_pc = rpc;
    io.halt        = h;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 128; i++) mem[i] = i;
    mem[127] = 32'hFFFFFFFF;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0);

    // reset state
    #12;
    chk("rst_imem_addr", 32'(io.imem_addr), 32'd0);
    chk("rst_ifid_pc", 32'(io.ifid_pc), 32'd0);
    chk("rst_instr", io.ifid_instr, 32'h00000013);
    chk("rst_opcode", 32'(io.ifid_opcode), 32'h13);
    chk("rst_valid", 32'(io.ifid_valid), 32'd0);
    chk("rst_halted", 32'(io.halted), 32'd0);
    chk("rst_count", io.fetch_count, 32'd0);

    // free-run: three edges
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      chk("run_ifid_pc", 32'(io.ifid_pc), 32'(4 * e));
      chk("run_instr", io.ifid_instr, 32'(e));
      chk("run_valid", 32'(io.ifid_valid), 32'd1);
      chk("run_count", io.fetch_count, 32'(e + 1));
    end
    chk("run_imem_addr", 32'(io.imem_addr), 32'd12);

    // stall two cycles with ifid_pc = 8
    drive(1'b1, 1'b0, '0, 1'b0);
    for (int e = 0; e < 2; e++) begin
      step();
      chk("stall_ifid_pc", 32'(io.ifid_pc), 32'd8);
      chk("stall_imem_addr", 32'(io.imem_addr), 32'd12);
      chk("stall_count", io.fetch_count, 32'd3);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    chk("unstall_ifid_pc", 32'(io.ifid_pc), 32'd12);
    chk("unstall_count", io.fetch_count, 32'd4);

    // redirect to 0x043 with concurrent stall
    drive(1'b1, 1'b1, 9'h043, 1'b0);
    step();
    chk("redir_valid", 32'(io.ifid_valid), 32'd0);
    chk("redir_instr", io.ifid_instr, 32'h00000013);
    chk("redir_imem_addr", 32'(io.imem_addr), 32'h040);
    chk("redir_ifid_pc", 32'(io.ifid_pc), 32'h010);
    chk("redir_count", io.fetch_count, 32'd4);
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    chk("redir2_ifid_pc", 32'(io.ifid_pc), 32'h040);
    chk("redir2_valid", 32'(io.ifid_valid), 32'd1);
    chk("redir2_instr", io.ifid_instr, 32'd16);
    chk("redir2_count", io.fetch_count, 32'd5);

    // redirect beats halt (ifid_valid = 1 here)
    drive(1'b0, 1'b1, 9'h080, 1'b1);
    step();
    chk("rvh_halted", 32'(io.halted), 32'd0);
    chk("rvh_imem_addr", 32'(io.imem_addr), 32'h080);
    chk("rvh_valid", 32'(io.ifid_valid), 32'd0);
    // halt against a bubble is ignored: normal fetch happens
    drive(1'b0, 1'b0, '0, 1'b1);
    step();
    chk("bub_halt_halted", 32'(io.halted), 32'd0);
    chk("bub_halt_ifid_pc", 32'(io.ifid_pc), 32'h080);
    chk("bub_halt_valid", 32'(io.ifid_valid), 32'd1);
    chk("bub_halt_count", io.fetch_count, 32'd6);

    // wrap: redirect to 0x1FC, then one fetch edge
    drive(1'b0, 1'b1, 9'h1FC, 1'b0);
    step();
    chk("wrap_pre_addr", 32'(io.imem_addr), 32'h1FC);
    drive(1'b0, 1'b0, '0, 1'b0);
    step();
    chk("wrap_imem_addr", 32'(io.imem_addr), 32'd0);
    chk("wrap_ifid_pc", 32'(io.ifid_pc), 32'h1FC);
    chk("wrap_instr", io.ifid_instr, 32'hFFFFFFFF);
    chk("wrap_opcode", 32'(io.ifid_opcode), 32'h7F);
    chk("wrap_count", io.fetch_count, 32'd7);

    // halt on the all-ones word, with stall
    drive(1'b1, 1'b0, '0, 1'b1);
    step();
    chk("halt_halted", 32'(io.halted), 32'd1);
    chk("halt_valid", 32'(io.ifid_valid), 32'd0);
    chk("halt_instr", io.ifid_instr, 32'h00000013);
    chk("halt_imem_addr", 32'(io.imem_addr), 32'd0);
    chk("halt_count", io.fetch_count, 32'd7);
    // redirect pulses and plain cycles while halted change nothing
    for (int e = 0; e < 3; e++) begin
      drive(1'b0, (e != 1), 9'h100, 1'b0);
      step();
      chk("hold_halted", 32'(io.halted), 32'd1);
      chk("hold_imem_addr", 32'(io.imem_addr), 32'd0);
      chk("hold_valid", 32'(io.ifid_valid), 32'd0);
      chk("hold_count", io.fetch_count, 32'd7);
    end

    // async reset while halted, between edges
    drive(1'b0, 1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_halted", 32'(io.halted), 32'd0);
    chk("arst_count", io.fetch_count, 32'd0);
    chk("arst_ifid_pc", 32'(io.ifid_pc), 32'd0);
    chk("arst_instr", io.ifid_instr, 32'h00000013);

    // run again, then async reset with a nonzero pc
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 0; e < 3; e++) step();
    chk("rerun_imem_addr", 32'(io.imem_addr), 32'd12);
    chk("rerun_count", io.fetch_count, 32'd3);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst2_imem_addr", 32'(io.imem_addr), 32'd0);
    chk("arst2_valid", 32'(io.ifid_valid), 32'd0);
    chk("arst2_count", io.fetch_count, 32'd0);
    chk("arst2_opcode", 32'(io.ifid_opcode), 32'h13);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
